rom_upload_ctrl: RTL and testbench

- Reads game ROM contents back out of SDRAM and returns them to the HPS over the ioctl upload interface, one byte per ioctl_rd strobe. This is the opposite direction of the ROM download path.
- Sits between hps_io (upload side) and an SDRAM port that uses the toggle req/ack protocol (port_req/port_ack, 16-bit word, byte-lane select).
- Keeps a single-word read cache, so the two bytes of one SDRAM word cost only one SDRAM access.
- Bounds every SDRAM access with a timeout.

---
 rtl/rom_upload_ctrl.sv | 150 +++++++++++++++
 tb/tb_rom_upload_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_upload_ctrl.sv
// Reads ROM bytes back from SDRAM (toggle req/ack port) for the HPS ioctl upload path.
// A one-word cache serves the second byte of a word; every SDRAM access has a timeout.
module rom_upload_ctrl #(
  parameter logic [7:0]  INDEX   = 8'd0,
  parameter logic [24:0] BASE    = 25'h0000000,
  parameter logic [24:0] SIZE    = 25'h001C320,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        ioctl_upload,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        port_req,
  input  logic        port_ack,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic        port_we,
  input  logic [15:0] port_q,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        r_state;
  logic          r_rd_last;
  logic          r_req;
  logic [22:0]   r_a;
  logic [23:0]   r_off;
  logic [7:0]    r_din;
  logic          r_wait;
  logic          r_err;
  logic          r_valid;
  logic [22:0]   r_cache_a;
  logic [15:0]   r_cache;
  logic [TW-1:0] r_tmo;

  logic [24:0] w_off;
  logic        w_borrow;
  logic        w_oor;
  logic        w_strobe;
  logic        w_hit;
  logic [7:0]  w_hit_byte;
  logic [7:0]  w_q_byte;
  logic        w_ack;
  logic        w_tmo;

  // The borrow bit flags addresses below BASE without a constant compare.
  assign {w_borrow, w_off} = {1'b0, ioctl_addr} - {1'b0, BASE};
  assign w_oor      = w_borrow | (w_off >= SIZE);
  assign w_strobe   = ioctl_rd & ~r_rd_last & ioctl_upload & (ioctl_index == INDEX);
  assign w_hit      = r_valid && (r_cache_a == w_off[23:1]);
  assign w_hit_byte = w_off[0] ? r_cache[15:8] : r_cache[7:0];
  assign w_q_byte   = r_off[0] ? port_q[15:8] : port_q[7:0];
  assign w_ack      = (port_ack == r_req);
  assign w_tmo      = (r_tmo == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_rd_last <= 1'b0;
      r_req     <= 1'b0;
      r_a       <= '0;
      r_off     <= '0;
      r_din     <= 8'h00;
      r_wait    <= 1'b0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_cache_a <= '0;
      r_cache   <= '0;
      r_tmo     <= '0;
    end else begin
      r_rd_last <= ioctl_rd;
      // Losing upload abandons the read; any outstanding toggle drains in S_REQ later.
      if (r_state != S_IDLE && !ioctl_upload) begin
        r_state <= S_IDLE;
        r_wait  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_strobe) begin
              if (w_oor) begin
                r_din <= 8'hFF;
              end else if (w_hit) begin
                r_din <= w_hit_byte;
              end else begin
                r_off   <= w_off[23:0];
                r_wait  <= 1'b1;
                r_tmo   <= '0;
                r_state <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (w_ack) begin
              r_req   <= ~r_req;
              r_a     <= r_off[23:1];
              r_tmo   <= '0;
              r_state <= S_WAIT;
            end else if (w_tmo) begin
              r_din   <= 8'hFF;
              r_err   <= 1'b1;
              r_wait  <= 1'b0;
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_WAIT: begin
            if (w_ack) begin
              r_cache   <= port_q;
              r_cache_a <= r_off[23:1];
              r_valid   <= 1'b1;
              r_din     <= w_q_byte;
              r_wait    <= 1'b0;
              r_state   <= S_IDLE;
            end else if (w_tmo) begin
              r_din   <= 8'hFF;
              r_err   <= 1'b1;
              r_wait  <= 1'b0;
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (ioctl_download) r_valid <= 1'b0;
    end
  end

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign port_req   = r_req;
  assign port_a     = r_a;
  assign port_ds    = 2'b11;
  assign port_we    = 1'b0;
  assign err        = r_err;

endmodule

// File: tb/tb_rom_upload_ctrl.sv
// Directed bench for rom_upload_ctrl: SDRAM toggle responder, byte/cache model, per-cycle compare.
module tb_rom_upload_ctrl;

  localparam logic [24:0] SIZE = 25'h001C320;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        ioctl_upload, ioctl_download, ioctl_rd;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, port_req, port_ack, port_we, err;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_q;

  always #5 clk = ~clk;

  rom_upload_ctrl #(.INDEX(8'd0), .BASE(25'h0), .SIZE(SIZE), .TIMEOUT(15)) dut (
    .clk(clk), .RST_N(RST_N), .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .port_req(port_req), .port_ack(port_ack),
    .port_a(port_a), .port_ds(port_ds), .port_we(port_we), .port_q(port_q), .err(err)
  );

  logic [15:0] mem [64];
  logic        hold;
  int          lat;
  int          mcnt;
  int          n_chk = 0;
  int          n_err = 0;
  int          toggles = 0;
  logic        prev_req = 1'b0;
  logic [22:0] cur_word = '0;
  logic        exp_err = 1'b0;
  logic        mon_en = 1'b0;
  logic        mv = 1'b0;
  logic [22:0] mword = '0;
  logic [7:0]  last_din = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte the HPS must see for an address: 0xFF past SIZE, else the addressed lane of the word.
  function automatic logic [7:0] model_byte(input logic [24:0] addr);
    logic [15:0] w;
    if (addr >= SIZE) return 8'hFF;
    w = mem[addr[6:1]];
    return addr[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM responder: acks a pending toggle after lat+1 cycles unless held off.
  always @(posedge clk) begin
    if (!RST_N) begin
      port_ack <= 1'b0;
      port_q   <= 16'h0000;
      mcnt     <= 0;
    end else if (port_req != port_ack && !hold) begin
      if (mcnt >= lat) begin
        port_ack <= port_req;
        port_q   <= mem[port_a[5:0]];
        mcnt     <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Per-cycle compare of the always-meaningful outputs plus toggle counting.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("port_we", 32'(port_we), 32'd0);
      chk("port_ds", 32'(port_ds), 32'd3);
      chk("err", 32'(err), 32'(exp_err));
      if (port_req !== prev_req) begin
        toggles++;
        chk("port_a", 32'(port_a), 32'(cur_word));
      end
    end
    prev_req = port_req;
  end

  task automatic start_read(input logic [24:0] addr, output logic w0, output logic [7:0] d0);
    @(negedge clk);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    @(posedge clk);
    #1;
    w0 = ioctl_wait;
    d0 = ioctl_din;
    @(negedge clk);
    ioctl_rd = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ioctl_wait !== 1'b0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: ioctl_wait still %b after %0d cycles, required 0", name, ioctl_wait, budget);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_read(input logic [24:0] addr, input string name, input logic use_lit,
                         input logic [7:0] lit);
    logic oor, miss, w0;
    logic [7:0] exp, d0;
    int t0;
    oor  = (addr >= SIZE);
    miss = !oor && !(mv && mword == addr[23:1]);
    exp  = model_byte(addr);
    cur_word = addr[23:1];
    t0 = toggles;
    start_read(addr, w0, d0);
    chk({name, " wait@1"}, 32'(w0), 32'(miss));
    if (!miss) chk({name, " din@1"}, 32'(d0), 32'(exp));
    wait_idle(100, name);
    settle();
    chk({name, " din"}, 32'(ioctl_din), 32'(exp));
    if (use_lit) chk({name, " din_lit"}, 32'(ioctl_din), 32'(lit));
    chk({name, " toggles"}, 32'(toggles - t0), miss ? 32'd1 : 32'd0);
    if (miss) begin
      mv    = 1'b1;
      mword = addr[23:1];
    end
    last_din = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic w0;
    logic [7:0] d0;
    int t0;
    for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0101 + 16'h0F00);
    mem[0] = 16'hA55A;
    mem[1] = 16'h1234;
    RST_N = 1'b0; ioctl_upload = 1'b0; ioctl_download = 1'b0; ioctl_rd = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; hold = 1'b0; lat = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst din", 32'(ioctl_din), 32'h00);
    chk("rst wait", 32'(ioctl_wait), 32'd0);
    chk("rst req", 32'(port_req), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk);
    RST_N = 1'b1;
    ioctl_upload = 1'b1;
    mon_en = 1'b1;

    do_read(25'd0, "a0", 1'b1, 8'h5A);
    do_read(25'd1, "a1_hit", 1'b1, 8'hA5);
    do_read(25'd2, "a2", 1'b1, 8'h34);
    do_read(25'd3, "a3_hit", 1'b1, 8'h12);
    do_read(SIZE, "oor", 1'b1, 8'hFF);
    do_read(SIZE - 25'd1, "last", 1'b1, 8'h1E);

    // Foreign index: no response at all.
    ioctl_index = 8'd1;
    t0 = toggles;
    start_read(25'd8, w0, d0);
    chk("idx wait", 32'(w0), 32'd0);
    chk("idx din", 32'(d0), 32'(last_din));
    settle();
    chk("idx toggles", 32'(toggles - t0), 32'd0);
    ioctl_index = 8'd0;

    // Withheld ack: WAIT times out 16 cycles after the toggle.
    hold = 1'b1;
    cur_word = 23'd2;
    t0 = toggles;
    start_read(25'd4, w0, d0);
    chk("tmo wait@1", 32'(w0), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k <= 16) begin
        chk("tmo wait_hi", 32'(ioctl_wait), 32'd1);
      end else begin
        chk("tmo wait_lo", 32'(ioctl_wait), 32'd0);
        chk("tmo din", 32'(ioctl_din), 32'hFF);
        chk("tmo err", 32'(err), 32'd1);
        exp_err = 1'b1;
      end
    end
    mv = 1'b0;
    last_din = 8'hFF;
    settle();
    chk("tmo toggles", 32'(toggles - t0), 32'd1);

    // Next miss must wait for the stale ack before toggling again.
    cur_word = 23'd3;
    t0 = toggles;
    start_read(25'd6, w0, d0);
    chk("drain wait@1", 32'(w0), 32'd1);
    repeat (3) @(posedge clk);
    settle();
    chk("drain held toggles", 32'(toggles - t0), 32'd0);
    chk("drain held wait", 32'(ioctl_wait), 32'd1);
    hold = 1'b0;
    wait_idle(100, "drain");
    settle();
    chk("drain din", 32'(ioctl_din), 32'(model_byte(25'd6)));
    chk("drain toggles", 32'(toggles - t0), 32'd1);
    mv = 1'b1;
    mword = 23'd3;
    last_din = model_byte(25'd6);

    // Upload drops while in WAIT.
    hold = 1'b1;
    cur_word = 23'd4;
    t0 = toggles;
    start_read(25'd8, w0, d0);
    chk("updrop wait@1", 32'(w0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ioctl_upload = 1'b0;
    @(posedge clk);
    #1;
    chk("updrop wait", 32'(ioctl_wait), 32'd0);
    chk("updrop din", 32'(ioctl_din), 32'(last_din));
    mv = 1'b0;
    @(negedge clk);
    ioctl_upload = 1'b1;
    hold = 1'b0;
    repeat (10) @(posedge clk);
    settle();
    chk("updrop toggles", 32'(toggles - t0), 32'd1);
    do_read(25'd7, "after_drop", 1'b0, 8'h00);

    // Download pulse between two same-word reads forces a refetch.
    do_read(25'd12, "dl_a", 1'b0, 8'h00);
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    ioctl_download = 1'b0;
    mv = 1'b0;
    do_read(25'd13, "dl_b", 1'b0, 8'h00);
    do_read(25'd12, "dl_c_hit", 1'b0, 8'h00);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
